// File: rtl/wb_arb.sv
// Write-back stage: round-robin arbitration of NUM_CH producer results onto the
// register-file write port and retire interface. Define WB_INSTRET_EN for the 64-bit instret_o counter.
module wb_arb #(
  parameter int NUM_CH  = 3,
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int INST_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           ch_valid_i,
  output logic [NUM_CH-1:0]           ch_ready_o,
  input  logic [NUM_CH*INST_W-1:0]    ch_inst_i,
  input  logic [NUM_CH*INST_W-1:0]    ch_instaddr_i,
  input  logic [NUM_CH-1:0]           ch_wen_i,
  input  logic [NUM_CH*RADDR_W-1:0]   ch_rd_addr_i,
  input  logic [NUM_CH*XLEN-1:0]      ch_rd_data_i,
  output logic                        regs_wen_o,
  output logic [RADDR_W-1:0]          rd_addr_o,
  output logic [XLEN-1:0]             rd_data_o,
  output logic                        retire_o,
  output logic [INST_W-1:0]           retire_inst_o,
  output logic [INST_W-1:0]           retire_instaddr_o
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]                 instret_o
`endif
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [NUM_CH-1:0]  gnt_vec;

  logic               sel_wen;
  logic [RADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic [INST_W-1:0]  sel_inst;
  logic [INST_W-1:0]  sel_iaddr;

  logic               wen_q, wen_d;
  logic               retire_q, retire_d;
  logic [RADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]    rd_data_q, rd_data_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic [INST_W-1:0]  iaddr_q, iaddr_d;

`ifdef WB_INSTRET_EN
  logic [63:0]        instret_q, instret_d;
`endif

  // Round-robin search: first valid channel at or above ptr, then wrap to those below it.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!gnt_any && ch_valid_i[c] && (c >= int'(ptr_q))) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!gnt_any && ch_valid_i[c] && (c < int'(ptr_q))) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(c);
      end
    end
    if (rst) begin
      gnt_any = 1'b0;
    end
  end

  // Handshake: a result moves when ch_valid_i[c] & ch_ready_o[c]; producers hold
  // valid and payload stable until ready, and ready never depends on anything but valid/ptr/rst.
  always_comb begin
    gnt_vec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      gnt_vec[c] = gnt_any && (gnt_idx == PTR_W'(c));
    end
  end

  assign ch_ready_o = gnt_vec;

  always_comb begin
    sel_wen   = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    sel_inst  = '0;
    sel_iaddr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_vec[c]) begin
        sel_wen   = ch_wen_i[c];
        sel_rd    = ch_rd_addr_i[c*RADDR_W +: RADDR_W];
        sel_data  = ch_rd_data_i[c*XLEN +: XLEN];
        sel_inst  = ch_inst_i[c*INST_W +: INST_W];
        sel_iaddr = ch_instaddr_i[c*INST_W +: INST_W];
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    wen_d     = 1'b0;
    retire_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    inst_d    = inst_q;
    iaddr_d   = iaddr_q;
`ifdef WB_INSTRET_EN
    instret_d = instret_q;
`endif
    if (gnt_any) begin
      ptr_d     = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
      // x0 still retires; only the register write is dropped.
      wen_d     = sel_wen & (sel_rd != '0);
      retire_d  = 1'b1;
      rd_addr_d = sel_rd;
      rd_data_d = sel_data;
      inst_d    = sel_inst;
      iaddr_d   = sel_iaddr;
`ifdef WB_INSTRET_EN
      instret_d = instret_q + 64'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      wen_q     <= 1'b0;
      retire_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      inst_q    <= '0;
      iaddr_q   <= '0;
`ifdef WB_INSTRET_EN
      instret_q <= '0;
`endif
    end else begin
      ptr_q     <= ptr_d;
      wen_q     <= wen_d;
      retire_q  <= retire_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      inst_q    <= inst_d;
      iaddr_q   <= iaddr_d;
`ifdef WB_INSTRET_EN
      instret_q <= instret_d;
`endif
    end
  end

  assign regs_wen_o        = wen_q;
  assign retire_o          = retire_q;
  assign rd_addr_o         = rd_addr_q;
  assign rd_data_o         = rd_data_q;
  assign retire_inst_o     = inst_q;
  assign retire_instaddr_o = iaddr_q;
`ifdef WB_INSTRET_EN
  assign instret_o         = instret_q;
`endif

endmodule

// File: tb/tb_wb_arb.sv
// Directed + constrained-random bench for wb_arb with a reference arbiter model
// and an expected-result queue; instret checks compile in with WB_INSTRET_EN.
module tb_wb_arb;
  localparam int NUM_CH  = 3;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int INST_W  = 32;
  localparam int REC_W   = 1 + RADDR_W + XLEN + 2 * INST_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]         valid;
  logic [NUM_CH-1:0]         wen;
  logic [RADDR_W-1:0]        rd_a   [NUM_CH];
  logic [XLEN-1:0]           data_a [NUM_CH];
  logic [INST_W-1:0]         inst_a [NUM_CH];
  logic [INST_W-1:0]         iaddr_a[NUM_CH];

  logic [NUM_CH-1:0]         ch_ready_o;
  logic [NUM_CH*INST_W-1:0]  ch_inst;
  logic [NUM_CH*INST_W-1:0]  ch_iaddr;
  logic [NUM_CH*RADDR_W-1:0] ch_rd;
  logic [NUM_CH*XLEN-1:0]    ch_data;
  logic                      regs_wen_o;
  logic [RADDR_W-1:0]        rd_addr_o;
  logic [XLEN-1:0]           rd_data_o;
  logic                      retire_o;
  logic [INST_W-1:0]         retire_inst_o;
  logic [INST_W-1:0]         retire_instaddr_o;
`ifdef WB_INSTRET_EN
  logic [63:0]               instret_o;
`endif

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_inst[c*INST_W +: INST_W]    = inst_a[c];
      ch_iaddr[c*INST_W +: INST_W]   = iaddr_a[c];
      ch_rd[c*RADDR_W +: RADDR_W]    = rd_a[c];
      ch_data[c*XLEN +: XLEN]        = data_a[c];
    end
  end

  wb_arb #(.NUM_CH(NUM_CH), .XLEN(XLEN), .RADDR_W(RADDR_W), .INST_W(INST_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .ch_valid_i        (valid),
    .ch_ready_o        (ch_ready_o),
    .ch_inst_i         (ch_inst),
    .ch_instaddr_i     (ch_iaddr),
    .ch_wen_i          (wen),
    .ch_rd_addr_i      (ch_rd),
    .ch_rd_data_i      (ch_data),
    .regs_wen_o        (regs_wen_o),
    .rd_addr_o         (rd_addr_o),
    .rd_data_o         (rd_data_o),
    .retire_o          (retire_o),
    .retire_inst_o     (retire_inst_o),
    .retire_instaddr_o (retire_instaddr_o)
`ifdef WB_INSTRET_EN
    ,
    .instret_o         (instret_o)
`endif
  );

  int               n_tests = 0;
  int               n_fail  = 0;
  int               m_ptr   = 0;
  int               last_g  = -1;
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] last_rec = '0;
  logic [63:0]      exp_cnt = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [NUM_CH-1:0] v, input int p, input logic r);
    if (r) return -1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (v[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic set_ch(input int c, input logic v, input logic w,
                        input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    valid[c]   = v;
    wen[c]     = w;
    rd_a[c]    = rd;
    data_a[c]  = d;
    inst_a[c]  = $urandom;
    iaddr_a[c] = $urandom & 32'hFFFF_FFFC;
  endtask

  // One clock: check ready against the model, push the expected record, then check outputs after the edge.
  task automatic cycle();
    int               g;
    logic [REC_W-1:0] rec;
    logic             was_rst;
    #1;
    was_rst = rst;
    g = model_grant(valid, m_ptr, rst);
    chk("ch_ready", 128'(ch_ready_o), (g >= 0) ? 128'(1) << g : 128'(0));
    if (g >= 0) begin
      exp_q.push_back({wen[g] && (rd_a[g] != '0), rd_a[g], data_a[g], inst_a[g], iaddr_a[g]});
      m_ptr = (g + 1) % NUM_CH;
      exp_cnt = exp_cnt + 64'd1;
    end
    if (was_rst) begin
      m_ptr = 0;
      exp_cnt = '0;
    end
    last_g = g;
    @(posedge clk);
    #1;
    if (was_rst) begin
      last_rec = '0;
      chk("rst_retire", 128'(retire_o), 128'(0));
      chk("rst_outs", 128'({regs_wen_o, rd_addr_o, rd_data_o, retire_inst_o, retire_instaddr_o}), 128'(0));
    end else if (g >= 0) begin
      chk("retire", 128'(retire_o), 128'(1));
      if (exp_q.size() == 0) begin
        chk("exp_q_empty", 128'(1), 128'(0));
      end else begin
        rec = exp_q.pop_front();
        last_rec = rec;
        chk("payload", 128'({regs_wen_o, rd_addr_o, rd_data_o, retire_inst_o, retire_instaddr_o}), 128'(rec));
      end
    end else begin
      chk("idle_retire", 128'(retire_o), 128'(0));
      chk("idle_wen", 128'(regs_wen_o), 128'(0));
      chk("idle_hold", 128'({rd_addr_o, rd_data_o, retire_inst_o, retire_instaddr_o}),
          128'(last_rec[REC_W-2:0]));
    end
`ifdef WB_INSTRET_EN
    chk("instret", 128'(instret_o), 128'(exp_cnt));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    valid = '0;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b0, 1'b0, '0, '0);

    // Reset state
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Single channel ch1, rd=5, 0xDEADBEEF
    set_ch(1, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cycle();
    chk("t1_wen", 128'(regs_wen_o), 128'(1));
    chk("t1_addr", 128'(rd_addr_o), 128'(5));
    chk("t1_data", 128'(rd_data_o), 128'(32'hDEAD_BEEF));
    valid = '0;

    // Idle gap: outputs hold, pointer stays at 2
    for (int i = 0; i < 3; i++) cycle();
    chk("gap_data", 128'(rd_data_o), 128'(32'hDEAD_BEEF));
    valid = '1;
    #1;
    chk("gap_ptr_grant", 128'(ch_ready_o), 128'(3'b100));
    valid = '0;

    // x0 write: retires without register write
    set_ch(0, 1'b1, 1'b1, 5'd0, 32'h0000_1234);
    cycle();
    chk("x0_retire", 128'(retire_o), 128'(1));
    chk("x0_wen", 128'(regs_wen_o), 128'(0));
    valid = '0;
    cycle();

    // Reset mid-stream with ch0/ch2 valid
    set_ch(0, 1'b1, 1'b1, 5'd7, $urandom);
    set_ch(2, 1'b1, 1'b1, 5'd9, $urandom);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("post_rst_first_addr", 128'(rd_addr_o), 128'(7));
    valid = '0;

    // All three valid for six cycles starting from ptr=0
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_order", 128'(last_g), 128'(i % NUM_CH));
      set_ch(last_g, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
`ifdef WB_INSTRET_EN
    chk("instret_six", 128'(instret_o), 128'(6));
`endif

    // Random traffic honouring hold-until-ready
    for (int i = 0; i < 60; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (c == last_g || !valid[c])
          set_ch(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), $urandom);
      end
      cycle();
    end

`ifdef WB_INSTRET_EN
    // Counter wrap
    valid = '0;
    force dut.instret_q = '1;
    #1;
    release dut.instret_q;
    exp_cnt = '1;
    set_ch(1, 1'b1, 1'b1, 5'd3, $urandom);
    cycle();
    chk("instret_wrap", 128'(instret_o), 128'(0));
`endif

    valid = '0;
    cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arb.md
# wb_arb

Parametrised write-back stage for the core. It accepts completed results from `NUM_CH` independent producers (ALU pipe, load/store unit, multiply/divide unit, ...) over valid/ready channels. A round-robin arbiter selects one result per cycle and registers it toward the register-file write port and the retire interface. It replaces the single-source pass-through write-back between mem_wb and regs, adding arbitration, back-pressure, x0 write suppression and an optional retired-instruction counter.

## Interface
- `NUM_CH`, 3, number of producer channels (2..8)
- `XLEN`, 32, register data width
- `RADDR_W`, 5, register address width
- `INST_W`, 32, instruction / instruction-address width
- `clk` in 1, single clock, all logic on rising edge
- `rst` in 1, synchronous active-high reset
- `ch_valid_i` in NUM_CH, channel c holds a completed result
- `ch_ready_o` out NUM_CH, one-hot grant; channel c's result is consumed this cycle
- `ch_inst_i` in NUM_CH*INST_W, instruction per channel (channel c at bits [c*INST_W +: INST_W]; same packing for all buses)
- `ch_instaddr_i` in NUM_CH*INST_W, instruction address per channel
- `ch_wen_i` in NUM_CH, result writes rd
- `ch_rd_addr_i` in NUM_CH*RADDR_W, destination register
- `ch_rd_data_i` in NUM_CH*XLEN, result data
- `regs_wen_o` out 1, register-file write enable
- `rd_addr_o` out RADDR_W, register-file write address
- `rd_data_o` out XLEN, register-file write data
- `retire_o` out 1, one instruction retired this cycle
- `retire_inst_o` out INST_W, retired instruction
- `retire_instaddr_o` out INST_W, retired instruction address
- `instret_o` out 64, retired-instruction count (present only with `WB_INSTRET_EN`)

## Operation
- Arbitration: round-robin pointer `ptr` in 0..NUM_CH-1. Grant goes to the first c with `ch_valid_i[c]=1`, searching ptr, ptr+1, ... modulo NUM_CH.
- `ch_ready_o` is combinational from `ch_valid_i` and `ptr`. It is one-hot or zero, and never asserted for a non-valid channel.
- Handshake: a transfer occurs when `ch_valid_i[c] & ch_ready_o[c]`. A producer holds valid and payload stable until it sees ready. The stage never stalls internally: exactly one transfer happens every cycle in which any channel is valid.
- On a transfer from channel g:
  - `ptr` <= (g+1) mod NUM_CH.
  - Output registers load channel g's payload and `retire_o` <= 1.
  - `regs_wen_o` <= `ch_wen_i[g]` & (`ch_rd_addr_i[g]` != 0). A write to x0 retires with the write suppressed.
- No valid channel: `ptr` holds, `retire_o` <= 0, `regs_wen_o` <= 0. Address, data, inst and instaddr outputs hold their last values.
- Ordering between channels targeting the same rd is the producers' responsibility. The block only guarantees one write per cycle, in grant order.
- Reset: `ptr`=0, `regs_wen_o`=0, `rd_addr_o`=0, `rd_data_o`=0, `retire_o`=0, `retire_inst_o`=0, `retire_instaddr_o`=0, `instret_o`=0. `ch_ready_o` is 0 while `rst`=1, so no transfer occurs during reset. A result offered during reset is not consumed and must be re-presented, or has already been flushed upstream.

## Timing
- Latency: 1 cycle from the accepting edge to `regs_wen_o`/`retire_o` valid. Outputs are pure flops.
- Throughput: 1 result per cycle aggregate.
- Starvation bound: a continuously valid channel is granted within NUM_CH cycles.
- `ch_ready_o` is a combinational path from `ch_valid_i`. Producers must not derive `ch_valid_i` from `ch_ready_o`.
- `rst` asserted mid-stream: the outputs clear on the next edge and the pending grant is discarded.

## Configuration
- `WB_INSTRET_EN` defined:
  - 64-bit `instret_o` counter, incremented by 1 on every cycle where a transfer occurs (including x0 and `ch_wen_i`=0 results).
  - Updates on the same edge as `retire_o`; wraps from 2^64-1 to 0.
  - Cleared by `rst`.
- `WB_INSTRET_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then single channel: ch1 valid, wen=1, rd=5, data=0xDEADBEEF -> `ch_ready_o`=3'b010 same cycle; next cycle `regs_wen_o`=1, `rd_addr_o`=5, `rd_data_o`=0xDEADBEEF, `retire_o`=1.
- All three channels valid for 6 cycles from ptr=0 -> grants 0,1,2,0,1,2; outputs follow with 1-cycle lag; `instret_o`=6 (with macro).
- x0 write: ch0 wen=1, rd=0, data=0x1234 -> `retire_o`=1, `regs_wen_o`=0; counter +1.
- Idle gap: one transfer, then no valid for 3 cycles -> `retire_o`=0, `regs_wen_o`=0, `rd_data_o` holds last value, `ptr` unchanged.
- Reset mid-stream: channels 0 and 2 valid, assert `rst` for one cycle -> `ch_ready_o`=0 that cycle; all outputs 0 next cycle; after release the first grant goes to ch0.
- Counter wrap (macro on): force `instret_o` to 2^64-1, one transfer -> `instret_o`=0.
